// File: rtl/json_pkg.sv
// Shared constants and state encoding for the streaming JSON pair counter.
package json_pkg;

    localparam logic [7:0] CH_LBRACE = 8'h7B;
    localparam logic [7:0] CH_RBRACE = 8'h7D;
    localparam logic [7:0] CH_QUOTE  = 8'h22;
    localparam logic [7:0] CH_COLON  = 8'h3A;
    localparam logic [7:0] CH_COMMA  = 8'h2C;
    localparam logic [7:0] CH_SP     = 8'h20;
    localparam logic [7:0] CH_TAB    = 8'h09;
    localparam logic [7:0] CH_LF     = 8'h0A;
    localparam logic [7:0] CH_CR     = 8'h0D;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_OPEN   = 4'd1,
        S_NEXT   = 4'd2,
        S_KEY    = 4'd3,
        S_COLON  = 4'd4,
        S_VSTART = 4'd5,
        S_VSTR   = 4'd6,
        S_VNUM   = 4'd7,
        S_VEND   = 4'd8,
        S_ERR    = 4'd9
    } json_state_e;

endpackage

// File: rtl/json_char_class.sv
// Combinational ASCII classifier: alphanumeric, decimal digit, whitespace.
module json_char_class
    import json_pkg::*;
(
    input  logic [7:0] char_in,
    output logic       is_alnum,
    output logic       is_digit,
    output logic       is_ws
);

    logic is_upper;
    logic is_lower;

    assign is_digit = (char_in >= 8'h30) && (char_in <= 8'h39);
    assign is_upper = (char_in >= 8'h41) && (char_in <= 8'h5A);
    assign is_lower = (char_in >= 8'h61) && (char_in <= 8'h7A);
    assign is_alnum = is_digit || is_upper || is_lower;
    assign is_ws    = (char_in == CH_SP) || (char_in == CH_TAB) ||
                      (char_in == CH_LF) || (char_in == CH_CR);

endmodule

// File: rtl/json_pair_counter_v2.sv
// Streaming flat-object JSON validator that counts key/value pairs per object.
// Define JSON_WS_SKIP_EN to tolerate whitespace between tokens inside objects.
//
// state  | meaning
// IDLE   | outside any object, waiting for '{'
// OPEN   | just saw '{', expecting key or '}'
// NEXT   | just saw ',', expecting another key
// KEY    | inside key string
// COLON  | key closed, expecting ':'
// VSTART | expecting start of value
// VSTR   | inside string value
// VNUM   | inside unquoted decimal value
// VEND   | value finished, expecting ',' or '}'
// ERR    | object invalid, waiting for '}'
module json_pair_counter_v2
    import json_pkg::*;
#(
    parameter int CNT_W = 8,
    parameter int OBJ_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       char,
    output logic [CNT_W-1:0] cur_num,
    output logic [CNT_W-1:0] max_num,
    output logic [OBJ_W-1:0] valid_cnt,
    output logic             obj_done,
    output logic             obj_valid
);

`ifdef JSON_WS_SKIP_EN
    localparam logic WS_SKIP = 1'b1;
`else
    localparam logic WS_SKIP = 1'b0;
`endif

    json_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             key_ne_q, key_ne_d;
    logic             val_ne_q, val_ne_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] cur_num_q, cur_num_d;
    logic [CNT_W-1:0] max_num_q, max_num_d;
    logic [OBJ_W-1:0] valid_cnt_q, valid_cnt_d;
    logic             obj_done_q, obj_done_d;
    logic             obj_valid_q, obj_valid_d;

    logic             is_alnum, is_digit, is_ws;
    logic             skip_ws;
    logic             cnt_full;
    logic [CNT_W-1:0] cnt_inc;
    logic             close;
    logic             close_good;
    logic [CNT_W-1:0] close_cnt;

    json_char_class u_class (
        .char_in  (char),
        .is_alnum (is_alnum),
        .is_digit (is_digit),
        .is_ws    (is_ws)
    );

    assign skip_ws  = WS_SKIP && is_ws;
    assign cnt_full = &cnt_q;
    assign cnt_inc  = cnt_q + CNT_W'(1);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        key_ne_d   = key_ne_q;
        val_ne_d   = val_ne_q;
        valid_d    = valid_q;
        close      = 1'b0;
        close_good = 1'b0;
        close_cnt  = cnt_q;

        unique case (state_q)
            S_IDLE: begin
                if (char == CH_LBRACE) begin
                    state_d = S_OPEN;
                    cnt_d   = '0;
                    valid_d = 1'b1;
                end
            end
            S_OPEN, S_NEXT: begin
                if (char == CH_QUOTE) begin
                    state_d  = S_KEY;
                    key_ne_d = 1'b0;
                end else if (char == CH_RBRACE) begin
                    // '}' right after ',' is a trailing comma and never valid
                    close      = 1'b1;
                    close_good = (state_q == S_OPEN) && valid_q;
                end else if (!skip_ws) begin
                    state_d = S_ERR;
                    valid_d = 1'b0;
                end
            end
            S_KEY: begin
                if (is_alnum) begin
                    key_ne_d = 1'b1;
                end else if (char == CH_QUOTE && key_ne_q) begin
                    state_d = S_COLON;
                end else begin
                    state_d = S_ERR;
                    valid_d = 1'b0;
                end
            end
            S_COLON: begin
                if (char == CH_COLON) begin
                    state_d = S_VSTART;
                end else if (!skip_ws) begin
                    state_d = S_ERR;
                    valid_d = 1'b0;
                end
            end
            S_VSTART: begin
                if (char == CH_QUOTE) begin
                    state_d  = S_VSTR;
                    val_ne_d = 1'b0;
                end else if (is_digit) begin
                    state_d = S_VNUM;
                end else if (!skip_ws) begin
                    state_d = S_ERR;
                    valid_d = 1'b0;
                end
            end
            S_VSTR: begin
                if (is_alnum) begin
                    val_ne_d = 1'b1;
                end else if (char == CH_QUOTE && val_ne_q && !cnt_full) begin
                    state_d = S_VEND;
                    cnt_d   = cnt_inc;
                end else begin
                    state_d = S_ERR;
                    valid_d = 1'b0;
                end
            end
            S_VNUM: begin
                if (is_digit) begin
                    state_d = S_VNUM;
                end else if ((char == CH_COMMA || char == CH_RBRACE || skip_ws) && cnt_full) begin
                    // Completing this pair would wrap the count
                    state_d = S_ERR;
                    valid_d = 1'b0;
                end else if (char == CH_COMMA) begin
                    state_d = S_NEXT;
                    cnt_d   = cnt_inc;
                end else if (char == CH_RBRACE) begin
                    close      = 1'b1;
                    close_good = valid_q;
                    close_cnt  = cnt_inc;
                end else if (skip_ws) begin
                    state_d = S_VEND;
                    cnt_d   = cnt_inc;
                end else begin
                    state_d = S_ERR;
                    valid_d = 1'b0;
                end
            end
            S_VEND: begin
                if (char == CH_COMMA) begin
                    state_d = S_NEXT;
                end else if (char == CH_RBRACE) begin
                    close      = 1'b1;
                    close_good = valid_q;
                end else if (!skip_ws) begin
                    state_d = S_ERR;
                    valid_d = 1'b0;
                end
            end
            S_ERR: begin
                if (char == CH_RBRACE) begin
                    close = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (close) begin
            state_d = S_IDLE;
        end
    end

    always_comb begin
        obj_done_d  = close;
        obj_valid_d = obj_valid_q;
        cur_num_d   = cur_num_q;
        max_num_d   = max_num_q;
        valid_cnt_d = valid_cnt_q;
        if (close) begin
            obj_valid_d = close_good;
            cur_num_d   = close_good ? close_cnt : '0;
            if (close_good) begin
                if (close_cnt > max_num_q) begin
                    max_num_d = close_cnt;
                end
                if (!(&valid_cnt_q)) begin
                    valid_cnt_d = valid_cnt_q + OBJ_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            key_ne_q    <= 1'b0;
            val_ne_q    <= 1'b0;
            valid_q     <= 1'b1;
            cur_num_q   <= '0;
            max_num_q   <= '0;
            valid_cnt_q <= '0;
            obj_done_q  <= 1'b0;
            obj_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            key_ne_q    <= key_ne_d;
            val_ne_q    <= val_ne_d;
            valid_q     <= valid_d;
            cur_num_q   <= cur_num_d;
            max_num_q   <= max_num_d;
            valid_cnt_q <= valid_cnt_d;
            obj_done_q  <= obj_done_d;
            obj_valid_q <= obj_valid_d;
        end
    end

    assign cur_num   = cur_num_q;
    assign max_num   = max_num_q;
    assign valid_cnt = valid_cnt_q;
    assign obj_done  = obj_done_q;
    assign obj_valid = obj_valid_q;

endmodule

// File: tb/tb_json_pair_counter_v2.sv
// Directed bench for json_pair_counter_v2: default widths plus a narrow CNT_W=2/OBJ_W=3 instance.
module tb_json_pair_counter_v2;

    logic        clk;
    logic        reset;
    logic [7:0]  char;

    logic [7:0]  cur_num, max_num;
    logic [15:0] valid_cnt;
    logic        obj_done, obj_valid;

    logic [1:0]  cur_num_w2, max_num_w2;
    logic [2:0]  valid_cnt_w2;
    logic        obj_done_w2, obj_valid_w2;

    int checks = 0;
    int errors = 0;
    logic seen_done;

    json_pair_counter_v2 dut (
        .clk       (clk),
        .reset     (reset),
        .char      (char),
        .cur_num   (cur_num),
        .max_num   (max_num),
        .valid_cnt (valid_cnt),
        .obj_done  (obj_done),
        .obj_valid (obj_valid)
    );

    json_pair_counter_v2 #(.CNT_W(2), .OBJ_W(3)) dut_w2 (
        .clk       (clk),
        .reset     (reset),
        .char      (char),
        .cur_num   (cur_num_w2),
        .max_num   (max_num_w2),
        .valid_cnt (valid_cnt_w2),
        .obj_done  (obj_done_w2),
        .obj_valid (obj_valid_w2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic send_char(input logic [7:0] c);
        char = c;
        @(posedge clk);
        #1;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) begin
            send_char(s[i]);
        end
    endtask

    task automatic chk_close(input string tag, input logic v, input int cur,
                             input int mx, input int vc);
        chk({tag, "_done"}, {31'd0, obj_done}, 32'd1);
        chk({tag, "_valid"}, {31'd0, obj_valid}, {31'd0, v});
        chk({tag, "_cur"}, {24'd0, cur_num}, cur);
        chk({tag, "_max"}, {24'd0, max_num}, mx);
        chk({tag, "_vcnt"}, {16'd0, valid_cnt}, vc);
    endtask

    initial begin
        reset = 1'b1;
        char  = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cur", {24'd0, cur_num}, 0);
        chk("rst_max", {24'd0, max_num}, 0);
        chk("rst_vcnt", {16'd0, valid_cnt}, 0);
        chk("rst_done", {31'd0, obj_done}, 0);
        chk("rst_valid", {31'd0, obj_valid}, 0);
        #2;
        reset = 1'b0;

        send_str("{\"a\":\"1\",\"b\":22}");
        chk_close("two_pairs", 1'b1, 2, 2, 1);
        send_char(8'h20);
        chk("done_one_cycle", {31'd0, obj_done}, 0);
        chk("valid_held", {31'd0, obj_valid}, 1);

        send_str("{}");
        chk_close("empty_obj", 1'b1, 0, 2, 2);
        send_str("{\"k\":\"\"}");
        chk_close("empty_value", 1'b0, 0, 2, 2);
        send_str("{\"a\":\"b\",}");
        chk_close("trailing_comma", 1'b0, 0, 2, 2);
        send_str("{\"\":\"x\"}");
        chk_close("empty_key", 1'b0, 0, 2, 2);

        send_char("}");
        chk("lone_rbrace_no_done", {31'd0, obj_done}, 0);
        send_str("{\"x\":5}");
        chk_close("back_to_back", 1'b1, 1, 2, 3);

        seen_done = 1'b0;
        for (int i = 0; i < 7; i++) begin
            send_char(i[0] ? "}" : "q");
            if (obj_done) seen_done = 1'b1;
        end
        chk("garbage_no_done", {31'd0, seen_done}, 0);

`ifdef JSON_WS_SKIP_EN
        send_str("{ \"a\" : 12 , \"b\":\"c\" }");
        chk_close("ws_stream", 1'b1, 2, 2, 4);
`else
        send_str("{ \"a\" : 12 , \"b\":\"c\" }");
        chk_close("ws_stream", 1'b0, 0, 2, 3);
`endif

        send_str("{\"ab");
        reset = 1'b1;
        #2;
        chk("midrst_cur", {24'd0, cur_num}, 0);
        chk("midrst_max", {24'd0, max_num}, 0);
        chk("midrst_vcnt", {16'd0, valid_cnt}, 0);
        chk("midrst_valid", {31'd0, obj_valid}, 0);
        @(posedge clk);
        #2;
        reset = 1'b0;
        send_str("{\"z\":\"1\"}");
        chk_close("after_reset", 1'b1, 1, 1, 1);

        send_str("{\"a\":\"1\",\"b\":\"2\",\"c\":\"3\"}");
        chk_close("three_pairs", 1'b1, 3, 3, 2);
        chk("w2_three_valid", {31'd0, obj_valid_w2}, 1);
        chk("w2_three_cur", {30'd0, cur_num_w2}, 3);
        chk("w2_three_max", {30'd0, max_num_w2}, 3);
        chk("w2_three_vcnt", {29'd0, valid_cnt_w2}, 2);

        send_str("{\"a\":\"1\",\"b\":\"2\",\"c\":\"3\",\"d\":\"4\"}");
        chk_close("four_pairs", 1'b1, 4, 4, 3);
        chk("w2_four_done", {31'd0, obj_done_w2}, 1);
        chk("w2_four_valid", {31'd0, obj_valid_w2}, 0);
        chk("w2_four_cur", {30'd0, cur_num_w2}, 0);
        chk("w2_four_max", {30'd0, max_num_w2}, 3);
        chk("w2_four_vcnt", {29'd0, valid_cnt_w2}, 2);

        for (int i = 0; i < 6; i++) begin
            send_str("{}");
        end
        chk("w2_vcnt_saturate", {29'd0, valid_cnt_w2}, 7);
        chk("main_vcnt_after_empties", {16'd0, valid_cnt}, 9);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/json_pair_counter_v2.md
Name: json_pair_counter_v2

Overview:
- Streaming JSON-subset validator: consumes one ASCII character per clock and counts key/value pairs in each flat object.
- Parametrised successor to the single-width object counter. Adds:
  - configurable counter widths
  - unquoted decimal-number values
  - strict trailing-comma rejection
  - saturating valid-object counter
  - registered per-object completion pulse
- Sits behind the character source feeding the checker; outputs go to status registers.

Parameters:
- CNT_W, 8, width of per-object pair count (cur_num, max_num)
- OBJ_W, 16, width of valid-object counter valid_cnt

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- char  in  8  ASCII character, one consumed every clock edge (no valid strobe)
- cur_num  out  CNT_W  pair count of most recently closed object; 0 if that object was invalid
- max_num  out  CNT_W  largest pair count among all valid objects since reset
- valid_cnt  out  OBJ_W  number of valid objects closed since reset, saturating
- obj_done  out  1  one-cycle pulse: an object closed on the last sampled char
- obj_valid  out  1  qualifies obj_done: 1 = closed object valid; held until next obj_done

Behaviour:
- Interface (already decided): one clock clk; reset is asynchronous and active-high.
- Reset values: all outputs 0, state IDLE, internal pair count 0, valid flag 1.
- Character classes:
  - alnum = 0-9 A-Z a-z
  - digit = 0-9
  - WS = 0x20 0x09 0x0A 0x0D
- All decisions are made on the edge sampling char; outputs are registered, visible the cycle after '}' is sampled.
- No bubble after close: the char following '}' is evaluated in IDLE, so "}{" starts a new object immediately.
- States and transitions (any unlisted char -> ERR):
  - IDLE: '{' -> OPEN (clear count, valid=1); all else ignored, including '}'.
  - OPEN (after '{'): '"' -> KEY; '}' -> close valid with 0 pairs.
  - NEXT (after ','): '"' -> KEY; '}' -> close INVALID (trailing comma).
  - KEY: alnum -> KEY (mark key non-empty); '"' -> COLON if key non-empty, else ERR.
  - COLON: ':' -> VSTART.
  - VSTART: '"' -> VSTR; digit -> VNUM.
  - VSTR: alnum -> VSTR (mark non-empty); '"' -> VEND if non-empty (pair complete), else ERR.
  - VNUM: digit -> VNUM. A terminator completes the pair:
    - ',' -> NEXT
    - '}' -> close
  - VEND: ',' -> NEXT; '}' -> close.
  - ERR: '}' -> close invalid; all else stays in ERR. '{' inside an object (nesting) -> ERR.
- Pair completion: count + 1. If count is already 2^CNT_W-1, the object is marked invalid and goes to ERR instead (no wrap).
- Close valid: cur_num <= count; max_num <= max(max_num, count); valid_cnt += 1, saturating at 2^OBJ_W-1; obj_done=1; obj_valid=1.
- Close invalid: cur_num <= 0; max_num and valid_cnt unchanged; obj_done=1; obj_valid=0.
- Return state after any close is IDLE. obj_done is low on every non-close cycle.
- Reset asserted mid-object: state and all outputs return to reset values immediately; the partial object is discarded.

Optional Feature:
- Macro: JSON_WS_SKIP_EN.
- Defined:
  - WS is ignored (state unchanged) in OPEN, NEXT, COLON, VSTART and VEND.
  - In VNUM, WS ends the number: pair completes, go to VEND.
  - WS inside KEY or VSTR -> ERR. WS in IDLE/ERR is ignored as before.
- Undefined: WS inside any in-object state -> ERR.

Decomposition:
- Package json_pkg holds:
  - character constants (LBRACE, RBRACE, QUOTE, COLON, COMMA, WS codes)
  - state enum/localparams
- Sub-module json_char_class: combinational classifier, char -> is_alnum, is_digit, is_ws. Instantiated once.

Test Plan:
- reset; stream {"a":"1","b":22} -> obj_done pulse after '}', obj_valid=1, cur_num=2, max_num=2, valid_cnt=1.
- then {} then {"k":""} -> first close: cur_num=0, obj_valid=1, valid_cnt=2; second close: cur_num=0, obj_valid=0, max_num stays 2, valid_cnt stays 2.
- {"a":"b",} -> obj_valid=0, cur_num=0 (trailing comma); {"":"x"} -> obj_valid=0.
- Back-to-back }{"x":5}: second object closes valid with cur_num=1. Also check garbage and a lone '}' in IDLE produce no obj_done.
- CNT_W=2: object with 4 pairs -> invalid, cur_num=0. Same with 3 pairs -> cur_num=3, max_num=3.
- With JSON_WS_SKIP_EN: { "a" : 12 , "b":"c" } -> valid, cur_num=2. Without the macro, the same stream -> obj_valid=0.
- Reset asserted mid-key: all outputs 0. Next object {"z":"1"} -> cur_num=1, valid_cnt=1.
